// File: rtl/ddr4_axi_cmd_arbiter.sv
// Shares the memory-controller command port between the AXI read and write command paths.
// Whole bursts are granted; contention is settled by starvation override, then QoS, then round-robin.
module ddr4_axi_cmd_arbiter #(
   parameter int C_MC_ADDR_WIDTH = 30,
   parameter int C_ID_WIDTH      = 4,
   parameter int C_STARVE_LIMIT  = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       rd_cmd_en,
   input  logic                       rd_cmd_en_last,
   input  logic [C_MC_ADDR_WIDTH-1:0] rd_cmd_byte_addr,
   input  logic [C_ID_WIDTH-1:0]      rd_id,
   input  logic [3:0]                 rd_qos,
   output logic                       rd_cmd_full,
   input  logic                       wr_cmd_en,
   input  logic                       wr_cmd_en_last,
   input  logic [C_MC_ADDR_WIDTH-1:0] wr_cmd_byte_addr,
   input  logic [C_ID_WIDTH-1:0]      wr_id,
   input  logic [3:0]                 wr_qos,
   output logic                       wr_cmd_full,
   output logic                       mc_cmd_en,
   output logic [2:0]                 mc_cmd_instr,
   output logic [C_MC_ADDR_WIDTH-1:0] mc_cmd_byte_addr,
   output logic [C_ID_WIDTH-1:0]      mc_cmd_id,
   input  logic                       mc_cmd_full,
   output logic                       grant_rd,
   output logic                       grant_wr,
   output logic                       starve_evt
);

   localparam logic [3:0] LP_LIMIT = 4'(C_STARVE_LIMIT);

   // Encoded so each grant is a flop output with no decode glitches.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RD_OWN = 2'b01,
      ST_WR_OWN = 2'b10
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_last_wr;
   logic [3:0] r_starve_rd;
   logic [3:0] r_starve_wr;
   logic       r_starve_evt;

   logic       w_arb;
   logic       w_win_wr;
   logic       w_forced;
   logic       w_starve_rd;
   logic       w_starve_wr;
   logic       w_rd_xfer_last;
   logic       w_wr_xfer_last;

   assign grant_rd   = r_state[0];
   assign grant_wr   = r_state[1];
   assign starve_evt = r_starve_evt;

   assign rd_cmd_full = mc_cmd_full | ~grant_rd;
   assign wr_cmd_full = mc_cmd_full | ~grant_wr;
   assign mc_cmd_en   = (grant_rd & rd_cmd_en) | (grant_wr & wr_cmd_en);

   always_comb begin
      mc_cmd_instr     = 3'b000;
      mc_cmd_byte_addr = '0;
      mc_cmd_id        = '0;
      if (grant_rd) begin
         mc_cmd_instr     = 3'b001;
         mc_cmd_byte_addr = rd_cmd_byte_addr;
         mc_cmd_id        = rd_id;
      end else if (grant_wr) begin
         mc_cmd_byte_addr = wr_cmd_byte_addr;
         mc_cmd_id        = wr_id;
      end
   end

   assign w_rd_xfer_last = grant_rd & rd_cmd_en & rd_cmd_en_last & ~mc_cmd_full;
   assign w_wr_xfer_last = grant_wr & wr_cmd_en & wr_cmd_en_last & ~mc_cmd_full;

   // Only requesters asserting cmd_en are eligible, so starvation needs the request too.
   assign w_starve_rd = rd_cmd_en & (r_starve_rd >= LP_LIMIT);
   assign w_starve_wr = wr_cmd_en & (r_starve_wr >= LP_LIMIT);
   assign w_forced    = w_starve_rd | w_starve_wr;

   always_comb begin
      w_win_wr = 1'b0;
      if (w_starve_rd && w_starve_wr) begin
         w_win_wr = ~r_last_wr;
      end else if (w_starve_rd) begin
         w_win_wr = 1'b0;
      end else if (w_starve_wr) begin
         w_win_wr = 1'b1;
      end else if (rd_cmd_en && wr_cmd_en) begin
         if (wr_qos > rd_qos) begin
            w_win_wr = 1'b1;
         end else if (wr_qos < rd_qos) begin
            w_win_wr = 1'b0;
         end else begin
            w_win_wr = ~r_last_wr;
         end
      end else begin
         w_win_wr = wr_cmd_en;
      end
   end

   always_comb begin
      w_arb       = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (rd_cmd_en || wr_cmd_en) begin
               w_arb = 1'b1;
            end
         end
         ST_RD_OWN: begin
            if (w_rd_xfer_last) begin
               if (wr_cmd_en) begin
                  w_arb = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_WR_OWN: begin
            if (w_wr_xfer_last) begin
               if (rd_cmd_en) begin
                  w_arb = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_arb) begin
         w_state_nxt = w_win_wr ? ST_WR_OWN : ST_RD_OWN;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Reset leaves write as last winner so the first tie goes to read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_wr    <= 1'b1;
         r_starve_rd  <= 4'd0;
         r_starve_wr  <= 4'd0;
         r_starve_evt <= 1'b0;
      end else begin
         r_starve_evt <= w_arb & w_forced;
         if (w_arb) begin
            r_last_wr <= w_win_wr;
            if (w_win_wr) begin
               r_starve_wr <= 4'd0;
               if (rd_cmd_en && (r_starve_rd != 4'hF)) begin
                  r_starve_rd <= r_starve_rd + 4'd1;
               end
            end else begin
               r_starve_rd <= 4'd0;
               if (wr_cmd_en && (r_starve_wr != 4'hF)) begin
                  r_starve_wr <= r_starve_wr + 4'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ddr4_axi_cmd_arbiter.sv
// Self-checking bench for ddr4_axi_cmd_arbiter: a directed vector table, burst-level
// scenarios and a randomized run, all compared against a burst-ownership reference model.
module tb_ddr4_axi_cmd_arbiter;

   localparam int AW  = 30;
   localparam int IW  = 4;
   localparam int LIM = 4;
   localparam logic [AW-1:0] TAB_RA = 30'h0000_1100;
   localparam logic [AW-1:0] TAB_WA = 30'h0200_2200;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          rd_cmd_en, rd_cmd_en_last;
   logic [AW-1:0] rd_cmd_byte_addr;
   logic [IW-1:0] rd_id;
   logic [3:0]    rd_qos;
   logic          rd_cmd_full;
   logic          wr_cmd_en, wr_cmd_en_last;
   logic [AW-1:0] wr_cmd_byte_addr;
   logic [IW-1:0] wr_id;
   logic [3:0]    wr_qos;
   logic          wr_cmd_full;
   logic          mc_cmd_en;
   logic [2:0]    mc_cmd_instr;
   logic [AW-1:0] mc_cmd_byte_addr;
   logic [IW-1:0] mc_cmd_id;
   logic          mc_cmd_full;
   logic          grant_rd, grant_wr, starve_evt;

   always #5 clk = ~clk;

   ddr4_axi_cmd_arbiter #(
      .C_MC_ADDR_WIDTH (AW),
      .C_ID_WIDTH      (IW),
      .C_STARVE_LIMIT  (LIM)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .rd_cmd_en        (rd_cmd_en),
      .rd_cmd_en_last   (rd_cmd_en_last),
      .rd_cmd_byte_addr (rd_cmd_byte_addr),
      .rd_id            (rd_id),
      .rd_qos           (rd_qos),
      .rd_cmd_full      (rd_cmd_full),
      .wr_cmd_en        (wr_cmd_en),
      .wr_cmd_en_last   (wr_cmd_en_last),
      .wr_cmd_byte_addr (wr_cmd_byte_addr),
      .wr_id            (wr_id),
      .wr_qos           (wr_qos),
      .wr_cmd_full      (wr_cmd_full),
      .mc_cmd_en        (mc_cmd_en),
      .mc_cmd_instr     (mc_cmd_instr),
      .mc_cmd_byte_addr (mc_cmd_byte_addr),
      .mc_cmd_id        (mc_cmd_id),
      .mc_cmd_full      (mc_cmd_full),
      .grant_rd         (grant_rd),
      .grant_wr         (grant_wr),
      .starve_evt       (starve_evt)
   );

   typedef struct {
      bit rdEn, rdLast, wrEn, wrLast, mcFull;
      bit eGrd, eGwr, eMcEn, eRdFull, eWrFull;
   } vec_t;

   vec_t vecs[13];

   int checks = 0;
   int errors = 0;

   // Requester behaviour: index 0 is the read path, 1 the write path.
   int            rem[2], gap[2], hold[2], cidx[2], fixLen[2];
   bit            active[2];
   bit            randMode, mcForce;
   logic [3:0]    qosS[2];
   logic [IW-1:0] bid[2];
   int            burstLog[$];
   int            rdXfer, rdMcEn, mcEnStall, evtCount, idleCnt;
   bit            sawGrant;

   // Reference model: owner -1 none, 0 read, 1 write.
   int mOwner, mLast;
   int mSt[2];
   bit mEvt;

   function automatic logic [AW-1:0] cmdAddr(input int s);
      logic [AW-1:0] base;
      base = (s == 0) ? 30'h0001_0000 : 30'h0200_0000;
      return base + AW'(cidx[s] * 64 + int'(bid[s]) * 4096);
   endfunction

   task automatic modelReset();
      mOwner = -1;
      mLast  = 1;
      mSt[0] = 0;
      mSt[1] = 0;
      mEvt   = 1'b0;
   endtask

   // Burst-level arbitration decision computed straight from the priority rules.
   task automatic modelArb(input bit pR, input bit pW);
      bit p[2];
      bit sv[2];
      int w;
      p[0] = pR;
      p[1] = pW;
      for (int s = 0; s < 2; s++) sv[s] = p[s] && (mSt[s] >= LIM);
      if (sv[0] && sv[1])      w = 1 - mLast;
      else if (sv[0])          w = 0;
      else if (sv[1])          w = 1;
      else if (pR && pW) begin
         if (rd_qos > wr_qos)      w = 0;
         else if (wr_qos > rd_qos) w = 1;
         else                      w = 1 - mLast;
      end else                 w = pR ? 0 : 1;
      if (p[1-w]) mSt[1-w] = (mSt[1-w] >= 15) ? 15 : mSt[1-w] + 1;
      mSt[w] = 0;
      mLast  = w;
      mOwner = w;
      mEvt   = sv[0] || sv[1];
   endtask

   task automatic modelStep();
      bit en[2];
      bit lst[2];
      en[0]  = rd_cmd_en;
      en[1]  = wr_cmd_en;
      lst[0] = rd_cmd_en_last;
      lst[1] = wr_cmd_en_last;
      mEvt   = 1'b0;
      if (mOwner < 0) begin
         if (en[0] || en[1]) modelArb(en[0], en[1]);
      end else if (en[mOwner] && lst[mOwner] && !mc_cmd_full) begin
         if (en[1-mOwner]) modelArb(en[0], en[1]);
         else              mOwner = -1;
      end
   endtask

   task automatic initStim();
      for (int s = 0; s < 2; s++) begin
         rem[s] = 0; gap[s] = 0; hold[s] = 0; cidx[s] = 0; fixLen[s] = 1;
         active[s] = 1'b0; qosS[s] = 4'd0; bid[s] = '0;
      end
      randMode = 1'b0; mcForce = 1'b0;
      burstLog.delete();
      rdXfer = 0; rdMcEn = 0; mcEnStall = 0; evtCount = 0; idleCnt = 0;
      sawGrant = 1'b0;
   endtask

   task automatic driveIdle();
      rd_cmd_en = 1'b0; rd_cmd_en_last = 1'b0; rd_cmd_byte_addr = '0; rd_id = '0; rd_qos = 4'd0;
      wr_cmd_en = 1'b0; wr_cmd_en_last = 1'b0; wr_cmd_byte_addr = '0; wr_id = '0; wr_qos = 4'd0;
      mc_cmd_full = 1'b0;
   endtask

   task automatic applyStimulus();
      for (int s = 0; s < 2; s++) begin
         if (rem[s] == 0 && active[s] && gap[s] == 0) begin
            rem[s]  = randMode ? int'($urandom_range(1, 4)) : fixLen[s];
            bid[s]  = bid[s] + 1'b1;
            cidx[s] = 0;
            if (randMode) qosS[s] = 4'($urandom_range(0, 3));
         end
         if (randMode && rem[s] > 0 && hold[s] == 0 && $urandom_range(0, 19) == 0)
            hold[s] = int'($urandom_range(1, 3));
      end
      rd_cmd_en        = (rem[0] > 0) && (hold[0] == 0);
      rd_cmd_en_last   = (rem[0] == 1);
      rd_cmd_byte_addr = cmdAddr(0);
      rd_id            = bid[0];
      rd_qos           = qosS[0];
      wr_cmd_en        = (rem[1] > 0) && (hold[1] == 0);
      wr_cmd_en_last   = (rem[1] == 1);
      wr_cmd_byte_addr = cmdAddr(1);
      wr_id            = bid[1];
      wr_qos           = qosS[1];
      mc_cmd_full      = randMode ? ($urandom_range(0, 3) == 0) : mcForce;
   endtask

   task automatic checkOutput(input string tag);
      logic [8+IW+AW-1:0] act, exp;
      logic eg0, eg1, eMcEn;
      logic [2:0] eInstr;
      logic [AW-1:0] eAddr;
      logic [IW-1:0] eId;
      eg0    = (mOwner == 0);
      eg1    = (mOwner == 1);
      eMcEn  = (eg0 && rd_cmd_en) || (eg1 && wr_cmd_en);
      eInstr = eg0 ? 3'b001 : 3'b000;
      eAddr  = eg0 ? rd_cmd_byte_addr : (eg1 ? wr_cmd_byte_addr : '0);
      eId    = eg0 ? rd_id : (eg1 ? wr_id : '0);
      exp = {eg0, eg1, mEvt, eMcEn, eInstr, mc_cmd_full | ~eg0, mc_cmd_full | ~eg1, eId, eAddr};
      act = {grant_rd, grant_wr, starve_evt, mc_cmd_en, mc_cmd_instr, rd_cmd_full, wr_cmd_full,
             mc_cmd_id, mc_cmd_byte_addr};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s t=%0t {grd,gwr,evt,en,instr,rfull,wfull,id,addr} actual=%h expected=%h",
                  tag, $time, act, exp);
      end
   endtask

   task automatic checkEq(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", tag, act, exp);
      end
   endtask

   task automatic checkLog(input string tag, input int exp[$]);
      string sa, se;
      bit bad;
      sa = ""; se = "";
      bad = (burstLog.size() != exp.size());
      foreach (burstLog[i]) sa = $sformatf("%s%0d", sa, burstLog[i]);
      foreach (exp[i]) begin
         se = $sformatf("%s%0d", se, exp[i]);
         if (i < burstLog.size() && burstLog[i] != exp[i]) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("[TB] FAIL %s burst order (0=rd,1=wr) actual=%s expected=%s", tag, sa, se);
      end
   endtask

   task automatic tick(input string tag);
      int s;
      bit xf[2];
      applyStimulus();
      #2;
      checkOutput(tag);
      if (mc_cmd_en && !mc_cmd_full) begin
         s = (mc_cmd_instr == 3'b001) ? 0 : 1;
         if ((s == 0 && rd_cmd_en_last) || (s == 1 && wr_cmd_en_last)) burstLog.push_back(s);
         if (s == 0) rdMcEn++;
      end
      if (starve_evt) evtCount++;
      if (grant_rd || grant_wr) sawGrant = 1'b1;
      else if (sawGrant)        idleCnt++;
      if (mc_cmd_en && mc_cmd_full) mcEnStall++;
      xf[0] = rd_cmd_en && !rd_cmd_full;
      xf[1] = wr_cmd_en && !wr_cmd_full;
      for (int k = 0; k < 2; k++) begin
         if (xf[k]) begin
            rem[k]--;
            cidx[k]++;
            if (k == 0) rdXfer++;
            if (rem[k] == 0) gap[k] = randMode ? int'($urandom_range(0, 3)) : 0;
         end else if (rem[k] == 0 && gap[k] > 0) begin
            gap[k]--;
         end
         if (hold[k] > 0) hold[k]--;
      end
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      initStim();
      driveIdle();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      modelReset();
      #2;
      checkOutput("reset_state");
      @(posedge clk);
      #1;
   endtask

   task automatic runUntil(input int n, input int maxC, input string tag);
      int c;
      c = 0;
      while (burstLog.size() < n && c < maxC) begin
         tick(tag);
         c++;
      end
      if (burstLog.size() < n) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s timeout bursts actual=%0d expected=%0d", tag, burstLog.size(), n);
      end
   endtask

   task automatic tickUntilRdXfer(input int n, input string tag);
      int c;
      c = 0;
      while (rdXfer < n && c < 40) begin
         tick(tag);
         c++;
      end
      checkEq({tag, "_xfer_reached"}, rdXfer, n);
   endtask

   initial begin
      // rdEn rdLast wrEn wrLast mcFull | grd gwr mcEn rdFull wrFull
      vecs[0]  = '{1,0,0,0,0, 0,0,0,1,1};
      vecs[1]  = '{1,0,0,0,0, 1,0,1,0,1};
      vecs[2]  = '{1,0,0,0,0, 1,0,1,0,1};
      vecs[3]  = '{1,1,0,0,1, 1,0,1,1,1};
      vecs[4]  = '{1,1,0,0,0, 1,0,1,0,1};
      vecs[5]  = '{0,0,0,0,0, 0,0,0,1,1};
      vecs[6]  = '{0,0,1,1,0, 0,0,0,1,1};
      vecs[7]  = '{0,0,1,1,0, 0,1,1,1,0};
      vecs[8]  = '{0,0,0,0,1, 0,0,0,1,1};
      vecs[9]  = '{1,0,1,0,0, 0,0,0,1,1};
      vecs[10] = '{1,1,1,0,0, 1,0,1,0,1};
      vecs[11] = '{0,0,1,1,0, 0,1,1,1,0};
      vecs[12] = '{0,0,0,0,0, 0,0,0,1,1};

      doReset();

      // Directed table: fixed addresses and IDs, expected outputs written out by hand.
      for (int i = 0; i < 13; i++) begin
         logic [8+AW+IW-1:0] act, exp;
         rd_cmd_en = vecs[i].rdEn;   rd_cmd_en_last = vecs[i].rdLast;
         wr_cmd_en = vecs[i].wrEn;   wr_cmd_en_last = vecs[i].wrLast;
         mc_cmd_full = vecs[i].mcFull;
         rd_cmd_byte_addr = TAB_RA;  rd_id = 4'h3; rd_qos = 4'd0;
         wr_cmd_byte_addr = TAB_WA;  wr_id = 4'h5; wr_qos = 4'd0;
         #2;
         exp = {vecs[i].eGrd, vecs[i].eGwr, vecs[i].eMcEn, vecs[i].eRdFull, vecs[i].eWrFull,
                vecs[i].eGrd ? 3'b001 : 3'b000,
                vecs[i].eGrd ? 4'h3 : (vecs[i].eGwr ? 4'h5 : 4'h0),
                vecs[i].eGrd ? TAB_RA : (vecs[i].eGwr ? TAB_WA : '0)};
         act = {grant_rd, grant_wr, mc_cmd_en, rd_cmd_full, wr_cmd_full, mc_cmd_instr,
                mc_cmd_id, mc_cmd_byte_addr};
         checks++;
         if (act !== exp) begin
            errors++;
            $display("[TB] FAIL vec%0d actual=%h expected=%h", i, act, exp);
         end
         @(posedge clk);
         #1;
      end

      // Single read burst of four commands.
      doReset();
      active[0] = 1'b1; fixLen[0] = 4;
      runUntil(1, 40, "rd_burst4");
      active[0] = 1'b0;
      repeat (3) tick("rd_burst4_idle");
      checkEq("rd_burst4_mc_en_cycles", rdMcEn, 4);

      // Equal QoS, both continuous: strict alternation without bubbles.
      doReset();
      active[0] = 1'b1; active[1] = 1'b1; fixLen[0] = 3; fixLen[1] = 3;
      runUntil(6, 200, "alternate");
      checkLog("alternate", '{0, 1, 0, 1, 0, 1});
      checkEq("alternate_idle_cycles", idleCnt, 0);

      // Write dominates on QoS until read starves.
      doReset();
      active[0] = 1'b1; active[1] = 1'b1; fixLen[0] = 2; fixLen[1] = 2;
      qosS[0] = 4'd2; qosS[1] = 4'd8;
      runUntil(10, 300, "starve");
      checkLog("starve", '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0});
      checkEq("starve_evt_pulses", evtCount, 2);

      // Ten cycles of MC backpressure mid read burst.
      doReset();
      active[0] = 1'b1; fixLen[0] = 6;
      tickUntilRdXfer(2, "stall_pre");
      mcForce = 1'b1;
      mcEnStall = 0;
      repeat (10) tick("stall");
      mcForce = 1'b0;
      checkEq("stall_mc_en_cycles", mcEnStall, 10);
      checkEq("stall_xfer_frozen", rdXfer, 2);
      runUntil(1, 40, "stall_post");
      active[0] = 1'b0;
      checkEq("stall_total_xfers", rdXfer, 6);

      // Asynchronous reset between clock edges in the middle of a write burst.
      doReset();
      active[0] = 1'b1; active[1] = 1'b1; fixLen[0] = 4; fixLen[1] = 4;
      qosS[0] = 4'd2; qosS[1] = 4'd8;
      runUntil(2, 100, "areset_pre");
      tick("areset_pre");
      applyStimulus();
      #2;
      reset_n = 1'b0;
      #1;
      checkEq("areset_grant_wr", int'(grant_wr), 0);
      checkEq("areset_mc_cmd_en", int'(mc_cmd_en), 0);
      doReset();
      active[0] = 1'b1; active[1] = 1'b1; fixLen[0] = 2; fixLen[1] = 2;
      qosS[0] = 4'd2; qosS[1] = 4'd8;
      runUntil(5, 200, "areset_post");
      checkLog("areset_post", '{1, 1, 1, 1, 0});
      checkEq("areset_post_evt", evtCount, 1);

      // Read drops cmd_en for three cycles mid burst; grant must not move.
      doReset();
      active[0] = 1'b1; active[1] = 1'b1; fixLen[0] = 5; fixLen[1] = 2;
      tickUntilRdXfer(2, "drop_pre");
      hold[0] = 3;
      runUntil(2, 100, "drop");
      checkLog("drop", '{0, 1});

      // Random traffic against the reference model.
      doReset();
      randMode = 1'b1;
      active[0] = 1'b1; active[1] = 1'b1;
      repeat (3000) tick("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
